gate_bist: RTL and testbench
============================

# gate_bist

Self-checking stimulus/response stage for the gate library: drives an exhaustive sweep of all 2^N_IN input vectors into a combinational gate under test and samples the gate's output after a settle window. It compares each sample against a built-in reference for the selected function and reports pass/fail, mismatch count and the first failing vector. It sits directly around a gate primitive: upstream as its input driver, downstream as the consumer of its `y`, so the gate is checked in hardware rather than only by a display-based bench.

## Interface
- `N_IN`, default 2: number of gate inputs, legal 1..8.
- `SETTLE`, default 2: cycles each vector is held before sampling, legal 1..15.
- `FUNC`, default 0: reference function code, one of AND=0, OR=1, NAND=2, NOR=3, XOR=4, XNOR=5.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: sweep request, sampled in IDLE only.
- `y_in`  in  1: gate-under-test output.
- `a_out`  out  N_IN: registered gate-input vector; bit 0 is LSB.
- `busy`  out  1: sweep in progress.
- `done`  out  1: one-cycle pulse at sweep end.
- `pass`  out  1: last sweep had zero mismatches. Valid from `done` until the next accepted `start`.
- `err_count`  out  N_IN+1: mismatches in the last sweep, range 0..2^N_IN.
- `fail_valid`  out  1: at least one mismatch seen in the current or last sweep.
- `first_fail_vec`  out  N_IN: first mismatching vector; meaningful only when `fail_valid`=1.

## Operation
- The FSM has three states: IDLE, APPLY and CHECK. A hold counter `cnt` is 4 bits wide.
- IDLE + `start`=1:
  - go to APPLY with `a_out`=0, `cnt`=SETTLE-1, `busy`=1;
  - clear `err_count`, `fail_valid`, `first_fail_vec` and `pass`.
- IDLE + `start`=0: outputs hold their values.
- APPLY: `a_out` is held. If `cnt`≠0, decrement it; if `cnt`=0, go to CHECK.
- CHECK: compute `exp` = reference(FUNC, `a_out`).
  - AND: reduction-AND of `a_out`. OR: reduction-OR. XOR: reduction-XOR.
  - NAND, NOR and XNOR are the inversions of those.
  - If `y_in`≠`exp`: increment `err_count`. If `fail_valid`=0, capture `first_fail_vec`=`a_out` and set `fail_valid`=1.
  - If `a_out`≠all-ones: increment `a_out`, reload `cnt`=SETTLE-1, go to APPLY.
  - If `a_out`=all-ones: go to IDLE, `a_out`=0, `busy`=0, `done`=1 for one cycle. Set `pass` to 1 when the final error count (including this cycle's compare) is zero.
- A mismatch on the last vector is counted before `pass` is evaluated.
- `err_count` cannot overflow (N_IN+1 bits), so there is no saturation logic.
- `start` while `busy`=1 is ignored. There is no queuing and no restart.
- `start` during the `done` cycle is accepted, because the FSM is already in IDLE; the new sweep begins on the next edge.
- `y_in` is sampled directly. The gate's combinational path from `a_out` must fit within SETTLE cycles. There is no synchroniser.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `cnt`=0, and every output is 0 (`a_out`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `first_fail_vec`).
- Reset mid-sweep aborts immediately; no `done` pulse is produced.
- Let edge 0 be the edge that samples `start`. Vector k is applied after edge k·(SETTLE+1) and sampled at edge (k+1)·(SETTLE+1).
- `done`, `pass` and the final `err_count` are visible after edge L = 2^N_IN·(SETTLE+1). `busy` is high after edge 0 through edge L-1.
- Throughput: one sweep per L+1 cycles with back-to-back starts.

## Structure
- Shared package `gate_pkg` holds:
  - the FUNC code localparams (GATE_AND … GATE_XNOR);
  - the FSM state typedef;
  - a pure function `gate_ref(func, vec)` that returns the expected output.
- One natural sub-module, `gate_ref_model`: combinational, parameters N_IN and FUNC, input `vec`, output `exp`. The FSM instantiates it; benches reuse it as a scoreboard.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle → all outputs 0 asynchronously, `a_out`=00; after release with `start`=0 for 10 cycles, outputs stay 0.
- N_IN=2, SETTLE=2, FUNC=AND, correct AND gate on `y_in`, `start` pulse → `a_out` holds 00, 01, 10, 11 for 3 cycles each; `done` after edge 12; `pass`=1, `err_count`=0, `fail_valid`=0.
- Same setup with `y_in` tied to 1 (stuck-at-1) → `err_count`=3, `fail_valid`=1, `first_fail_vec`=00, `pass`=0.
- Same setup, second `start` pulse at edge 5 → ignored; exactly one `done`, after edge 12. Then `start` in the `done` cycle → a new sweep starts and `done` follows 12 edges later.
- Reset asserted while `a_out`=10 → immediate IDLE with all outputs 0 and no `done`. A following `start` runs a full clean sweep with `pass`=1.
- N_IN=3, SETTLE=2, FUNC=XOR against a gate with vector 101 forced wrong → 8 vectors; `done` after edge 24; `err_count`=1, `first_fail_vec`=101, `pass`=0.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate BIST: function codes, FSM states and the
// reference evaluation of a gate over an up-to-MAX_IN-bit input vector.
package gate_pkg;

  localparam int unsigned MAX_IN = 8;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [FUNC_W-1:0] GATE_AND  = 3'd0;
  localparam logic [FUNC_W-1:0] GATE_OR   = 3'd1;
  localparam logic [FUNC_W-1:0] GATE_NAND = 3'd2;
  localparam logic [FUNC_W-1:0] GATE_NOR  = 3'd3;
  localparam logic [FUNC_W-1:0] GATE_XOR  = 3'd4;
  localparam logic [FUNC_W-1:0] GATE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // Only the low n_in bits of vec take part in the reduction.
  function automatic logic gate_ref(input logic [FUNC_W-1:0] func,
                                    input logic [MAX_IN-1:0] vec,
                                    input int                n_in);
    logic [MAX_IN-1:0] mask;
    logic              r_and;
    logic              r_or;
    logic              r_xor;
    logic              r;
    for (int i = 0; i < int'(MAX_IN); i++) begin
      mask[i] = (i < n_in);
    end
    r_and = &(vec | ~mask);
    r_or  = |(vec & mask);
    r_xor = ^(vec & mask);
    case (func)
      GATE_AND:  r = r_and;
      GATE_OR:   r = r_or;
      GATE_NAND: r = ~r_and;
      GATE_NOR:  r = ~r_or;
      GATE_XOR:  r = r_xor;
      GATE_XNOR: r = ~r_xor;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference output for the selected gate function.
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter int unsigned FUNC = 0
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp
);

  always_comb begin
    exp = gate_ref(FUNC_W'(FUNC), MAX_IN'(vec), int'(N_IN));
  end

endmodule

// File: rtl/gate_bist.sv
// Exhaustive stimulus/response BIST around a single combinational gate:
// sweeps every input vector, samples y_in after a settle window, and scores it.
module gate_bist
  import gate_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned FUNC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              y_in,
  output logic [N_IN-1:0]   a_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int unsigned ERR_W = N_IN + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   a_q, a_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic              exp_c;
  logic              mismatch_c;

  gate_ref_model #(.N_IN(N_IN), .FUNC(FUNC)) u_ref (
    .vec (a_q),
    .exp (exp_c)
  );

  assign mismatch_c = (y_in != exp_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Sweep sequencing and scoring; done is the only self-clearing output.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_APPLY;
          a_d          = '0;
          cnt_d        = CNT_RELOAD;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end
      ST_APPLY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mismatch_c) begin
          err_d = err_q + ERR_W'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = a_q;
          end
        end
        if (&a_q) begin
          state_d = ST_IDLE;
          a_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // The last vector's compare counts toward the verdict.
          pass_d  = !mismatch_c && (err_q == '0);
        end else begin
          state_d = ST_APPLY;
          a_d     = a_q + N_IN'(1);
          cnt_d   = CNT_RELOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_out          = a_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: a 2-input AND instance and a 3-input XOR instance with
// a gate whose vector 101 is wrong; expected vectors and verdicts are queued.
module tb_gate_bist;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start2, y2, busy2, done2, pass2, fv2;
  logic [1:0] a2, ff2;
  logic [2:0] err2;
  logic       start3, y3, busy3, done3, pass3, fv3;
  logic [2:0] a3, ff3;
  logic [3:0] err3;
  bit         stuck2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] err;
    logic       fv;
    logic [2:0] ff;
    logic       pass;
  } res_t;

  logic [2:0] vec_q[$];
  res_t       res_q[$];

  // Gates under test, modelled independently of the DUT's reference.
  assign y2 = stuck2 ? 1'b1 : &a2;
  assign y3 = (^a3) ^ (a3 == 3'b101);

  gate_bist #(.N_IN(2), .SETTLE(2), .FUNC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .y_in(y2), .a_out(a2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_vec(ff2)
  );

  gate_bist #(.N_IN(3), .SETTLE(2), .FUNC(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .y_in(y3), .a_out(a3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail_vec(ff3)
  );

  task automatic test_reset();
    rst_n = 1'b1; start2 = 1'b0; start3 = 1'b0; stuck2 = 1'b0;
    #12 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a2, busy2, done2, pass2, err2, fv2, ff2} !== 10'd0) begin
      n_fail++; $display("FAIL reset_async2 got %b want 0", {a2, busy2, done2, pass2, err2, fv2, ff2});
    end
    n_checks++;
    if ({a3, busy3, done3, pass3, err3, fv3, ff3} !== 14'd0) begin
      n_fail++; $display("FAIL reset_async3 got %b want 0", {a3, busy3, done3, pass3, err3, fv3, ff3});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({a2, busy2, done2, pass2, err2, fv2, ff2, a3, busy3, done3, pass3, err3, fv3, ff3} !== 24'd0) begin
        n_fail++; $display("FAIL reset_idle cycle %0d outputs not zero", i);
      end
    end
  endtask

  // One 2-input AND sweep; optional stray start at loop index inject,
  // optional start already raised in the previous done cycle, optional chain.
  task automatic sweep2(input bit stuck, input int inject, input bit started, input bit chain);
    res_t       r;
    int         errs;
    logic [2:0] first;
    logic [1:0] vv;
    logic [2:0] e;
    logic       yv;
    errs = 0; first = '0;
    stuck2 = stuck;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      yv = stuck ? 1'b1 : &vv;
      for (int h = 0; h < 3; h++) vec_q.push_back(3'(v));
      if (yv != &vv) begin
        if (errs == 0) first = 3'(v);
        errs++;
      end
    end
    r.err = 4'(errs); r.fv = (errs != 0); r.ff = first; r.pass = (errs == 0);
    res_q.push_back(r);
    if (!started) begin
      @(posedge clk); #1 start2 = 1'b1;
    end
    @(posedge clk); #1 start2 = 1'b0;
    n_checks++;
    if ({pass2, fv2, err2} !== 5'd0) begin
      n_fail++; $display("FAIL start_clear2 got %b want 00000", {pass2, fv2, err2});
    end
    for (int i = 0; i < 12; i++) begin
      e = vec_q.pop_front();
      n_checks++;
      if (a2 !== e[1:0] || busy2 !== 1'b1 || done2 !== 1'b0) begin
        n_fail++; $display("FAIL sweep2_cycle%0d a=%b busy=%b done=%b want a=%b busy=1 done=0", i, a2, busy2, done2, e[1:0]);
      end
      if (i == inject) start2 = 1'b1;
      if (i == inject + 1) start2 = 1'b0;
      @(posedge clk); #1;
    end
    r = res_q.pop_front();
    n_checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || a2 !== 2'b00) begin
      n_fail++; $display("FAIL sweep2_end done=%b busy=%b a=%b want 1 0 00", done2, busy2, a2);
    end
    n_checks++;
    if (err2 !== r.err[2:0] || fv2 !== r.fv || pass2 !== r.pass) begin
      n_fail++; $display("FAIL sweep2_result err=%0d fv=%b pass=%b want %0d %b %b", err2, fv2, pass2, r.err, r.fv, r.pass);
    end
    if (r.fv) begin
      n_checks++;
      if (ff2 !== r.ff[1:0]) begin
        n_fail++; $display("FAIL sweep2_first got %b want %b", ff2, r.ff[1:0]);
      end
    end
    if (chain) start2 = 1'b1;
  endtask

  task automatic test_and_clean();
    sweep2(1'b0, -10, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_at_1();
    sweep2(1'b1, -10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sweep2(1'b0, 4, 1'b0, 1'b1);
    sweep2(1'b0, -10, 1'b1, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (done2 !== 1'b0 || busy2 !== 1'b0 || pass2 !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold2 done=%b busy=%b pass=%b want 0 0 1", done2, busy2, pass2);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (a2 == 2'b10) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL abort_reach a=%b want 10 within 20 cycles", a2);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a2, busy2, done2, pass2, err2, fv2, ff2} !== 10'd0) begin
      n_fail++; $display("FAIL abort_reset got %b want 0", {a2, busy2, done2, pass2, err2, fv2, ff2});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done2 !== 1'b0 || busy2 !== 1'b0) begin
        n_fail++; $display("FAIL abort_nodone cycle %0d done=%b busy=%b want 0 0", i, done2, busy2);
      end
    end
    sweep2(1'b0, -10, 1'b0, 1'b0);
  endtask

  task automatic test_xor3();
    res_t       r;
    int         errs;
    logic [2:0] first;
    logic [2:0] vv;
    logic [2:0] e;
    logic       yv;
    errs = 0; first = '0;
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      yv = (^vv) ^ (vv == 3'b101);
      for (int h = 0; h < 3; h++) vec_q.push_back(vv);
      if (yv != ^vv) begin
        if (errs == 0) first = vv;
        errs++;
      end
    end
    r.err = 4'(errs); r.fv = (errs != 0); r.ff = first; r.pass = (errs == 0);
    res_q.push_back(r);
    @(posedge clk); #1 start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      e = vec_q.pop_front();
      n_checks++;
      if (a3 !== e || busy3 !== 1'b1 || done3 !== 1'b0) begin
        n_fail++; $display("FAIL sweep3_cycle%0d a=%b busy=%b done=%b want a=%b busy=1 done=0", i, a3, busy3, done3, e);
      end
      @(posedge clk); #1;
    end
    r = res_q.pop_front();
    n_checks++;
    if (done3 !== 1'b1 || busy3 !== 1'b0 || a3 !== 3'b000) begin
      n_fail++; $display("FAIL sweep3_end done=%b busy=%b a=%b want 1 0 000", done3, busy3, a3);
    end
    n_checks++;
    if (err3 !== r.err || fv3 !== r.fv || pass3 !== r.pass || ff3 !== r.ff) begin
      n_fail++; $display("FAIL sweep3_result err=%0d fv=%b pass=%b ff=%b want %0d %b %b %b", err3, fv3, pass3, ff3, r.err, r.fv, r.pass, r.ff);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done3 !== 1'b0 || err3 !== r.err || pass3 !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold3 done=%b err=%0d pass=%b want 0 %0d 0", done3, err3, pass3, r.err);
    end
  endtask

  initial begin
    test_reset();
    test_and_clean();
    test_stuck_at_1();
    test_back_to_back();
    test_reset_abort();
    test_xor3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
